panel_scan_scheduler: RTL and testbench
=======================================

Name: panel_scan_scheduler

Overview:
- Sequences row-multiplexed scanning of the word panel.
- Per row: fetches the row's column pattern from the frame source over a req/ack handshake, blanks all rows for a programmable interval, then drives that row for a programmable dwell.
- Walks rows 0..ROWS-1 and wraps, flagging each frame start.
- Sits between the frame/word-select logic and the panel row/column drivers. Replaces free-running count-to counters for scan timing.

Parameters:
ROWS, 8, number of panel rows scanned; ≥2
COLS, 16, column bits per row
DWELL_W, 16, width of dwell count input
BLANK_W, 8, width of blank count input

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  scan enable
dwell  input  DWELL_W  SHOW length in cycles; 0 treated as 1
blank  input  BLANK_W  BLANK length in cycles; 0 treated as 1
fetch_req  output  1  row-data request, held until acknowledged
fetch_row  output  $clog2(ROWS)  row index being fetched; stable while fetch_req=1
fetch_ack  input  1  frame source: fetch_data valid this cycle
fetch_data  input  COLS  column pattern for fetch_row
row_sel  output  ROWS  one-hot row drive; all-zero when blanked
col_data  output  COLS  column drive for the selected row
frame_start  output  1  one-cycle pulse at start of row 0 fetch

Behaviour:
- Reset (reset=0, asynchronous, overrides everything):
  - State is IDLE; row index, fetch_row, timer and shadow register are 0.
  - fetch_req, row_sel, col_data and frame_start are 0.
- States: IDLE, FETCH, BLANK, SHOW. All outputs are registered.
- IDLE:
  - Outputs are zero.
  - When en=1 at a clock edge, go to FETCH with row=0.
  - Next cycle: fetch_req=1 and frame_start=1 (one cycle).
- FETCH:
  - fetch_req=1; fetch_row=row; row_sel=0; col_data=0.
  - fetch_ack is sampled only while fetch_req=1. Ack in the first FETCH cycle is legal (zero-wait).
  - On ack, latch fetch_data into the shadow register. Next cycle: fetch_req=0, go to BLANK.
  - fetch_ack while not in FETCH is ignored.
  - With ack L cycles after req rises, FETCH lasts L+1 cycles.
- BLANK:
  - row_sel=0. Timer counts on [0, max(blank,1)).
  - blank is captured on BLANK entry; later changes do not affect the current interval.
  - On terminal count, go to SHOW.
- SHOW:
  - row_sel=one-hot(row); col_data=shadow.
  - Lasts max(dwell,1) cycles; dwell is captured on SHOW entry.
  - On terminal count:
    - row==ROWS-1: row wraps to 0.
    - else: row increments.
    - en=1: go to FETCH, asserting frame_start when the new row is 0.
    - en=0: go to IDLE and clear outputs next cycle.
- en deassert mid-row: the current row always completes its full FETCH/BLANK/SHOW. No truncation.
- Restart after IDLE always begins at row 0 with frame_start.
- Row period = (L+1) + max(blank,1) + max(dwell,1) cycles. Frame period = sum over ROWS.
- row_sel is never non-zero outside SHOW. Never more than one bit set.
- Timers and row counter wrap only as specified. No width overflow: timer width = max(DWELL_W, BLANK_W).

Test Plan:
1. ROWS=4, dwell=5, blank=2, ack same cycle as req rise:
   - row_sel = 0001×5, 0000×3, 0010×5, 0000×3, 0100×5, …
   - frame_start pulses every 32 cycles; fetch_row = 0,1,2,3,0.
2. fetch_ack delayed 3 cycles after req rise:
   - fetch_req high exactly 4 cycles, fetch_row stable throughout.
   - col_data in SHOW equals fetch_data on the ack cycle; row period 11 with dwell=5, blank=2.
3. dwell=0, blank=0, zero-wait ack:
   - each state lasts 1 cycle; row period 3; frame period 12 with ROWS=4.
4. en dropped during SHOW of row 2:
   - row 2 holds full dwell, then IDLE; row_sel=0, no further fetch_req.
   - Re-assert en: fetch_req next cycle with fetch_row=0 and frame_start=1.
5. Change dwell 5→9 mid-SHOW of row 1:
   - row 1 still shows 5 cycles; row 2 shows 9.
   - Spurious fetch_ack pulses during BLANK/SHOW are ignored.
6. Assert reset low asynchronously mid-SHOW, between clock edges:
   - row_sel, col_data and fetch_req go 0 immediately.
   - After release with en=1, the sequence restarts at row 0 with frame_start.

Source files
------------

// File: rtl/panel_scan_scheduler.sv
// ---------------------------------------------------------------------------
// panel_scan_scheduler
//
// Row-multiplexed scan sequencer for the word panel. For every row it
//   1. fetches the row's column pattern from the frame source (req/ack),
//   2. blanks all rows for max(blank,1) cycles,
//   3. drives the row for max(dwell,1) cycles,
// then moves to the next row, wrapping ROWS-1 -> 0 and pulsing frame_start
// at the start of each row-0 fetch. A row that has started always runs to
// completion; dropping en only stops the scan at the end of SHOW.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   en           scan enable
//   dwell        SHOW length in cycles (0 behaves as 1), captured on SHOW entry
//   blank        BLANK length in cycles (0 behaves as 1), captured on BLANK entry
//   fetch_req    row-data request, held until fetch_ack
//   fetch_row    row index being fetched, stable while fetch_req=1
//   fetch_ack    frame source: fetch_data valid this cycle
//   fetch_data   column pattern for fetch_row
//   row_sel      one-hot row drive, zero outside SHOW
//   col_data     column drive for the selected row, zero outside SHOW
//   frame_start  one-cycle pulse with the first cycle of every row-0 fetch
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module panel_scan_scheduler #(
    parameter int ROWS    = 8,
    parameter int COLS    = 16,
    parameter int DWELL_W = 16,
    parameter int BLANK_W = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  en,
    input  logic [DWELL_W-1:0]                    dwell,
    input  logic [BLANK_W-1:0]                    blank,
    output logic                                  fetch_req,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] fetch_row,
    input  logic                                  fetch_ack,
    input  logic [COLS-1:0]                       fetch_data,
    output logic [ROWS-1:0]                       row_sel,
    output logic [COLS-1:0]                       col_data,
    output logic                                  frame_start
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    // One shared timer serves both BLANK and SHOW, so it must hold the wider count.
    localparam int TW = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_BLANK = 2'd2,
        ST_SHOW  = 2'd3
    } state_t;

    // Terminal count for a length input: a length of 0 behaves as 1.
    function automatic logic [TW-1:0] term_count(input logic [TW-1:0] len);
        logic [TW-1:0] tc;
        if (len == {TW{1'b0}}) begin
            tc = {TW{1'b0}};
        end else begin
            tc = len - TW'(1);
        end
        return tc;
    endfunction

    // One-hot decode of a row index onto the row drivers.
    function automatic logic [ROWS-1:0] row_onehot(input logic [RW-1:0] idx);
        logic [ROWS-1:0] oh;
        oh = {ROWS{1'b0}};
        for (int k = 0; k < ROWS; k++) begin
            oh[k] = (RW'(k) == idx);
        end
        return oh;
    endfunction

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [TW-1:0]     limit_q, limit_d;
    logic [COLS-1:0]   shadow_q, shadow_d;
    logic              fetch_req_q, fetch_req_d;
    logic [RW-1:0]     fetch_row_q, fetch_row_d;
    logic [ROWS-1:0]   row_sel_q, row_sel_d;
    logic [COLS-1:0]   col_data_q, col_data_d;
    logic              frame_start_q, frame_start_d;

    logic [RW-1:0]     row_inc_s;
    logic              timer_done_s;

    // Row index that follows the current one, wrapping after the last row.
    always_comb begin
        if (row_q == RW'(ROWS - 1)) begin
            row_inc_s = {RW{1'b0}};
        end else begin
            row_inc_s = row_q + RW'(1);
        end
    end

    assign timer_done_s = (timer_q == limit_q);

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        timer_d       = timer_q;
        limit_d       = limit_q;
        shadow_d      = shadow_q;
        fetch_req_d   = 1'b0;
        fetch_row_d   = fetch_row_q;
        row_sel_d     = {ROWS{1'b0}};
        col_data_d    = {COLS{1'b0}};
        frame_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    // A restart always begins a fresh frame at row 0.
                    state_d       = ST_FETCH;
                    row_d         = {RW{1'b0}};
                    fetch_req_d   = 1'b1;
                    fetch_row_d   = {RW{1'b0}};
                    frame_start_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FETCH: begin
                if (fetch_req_q && fetch_ack) begin
                    shadow_d = fetch_data;
                    state_d  = ST_BLANK;
                    timer_d  = {TW{1'b0}};
                    limit_d  = term_count(TW'(blank));
                end else begin
                    fetch_req_d = 1'b1;
                end
            end

            ST_BLANK: begin
                if (timer_done_s) begin
                    // Entering SHOW: dwell is frozen here for the whole interval.
                    state_d    = ST_SHOW;
                    timer_d    = {TW{1'b0}};
                    limit_d    = term_count(TW'(dwell));
                    row_sel_d  = row_onehot(row_q);
                    col_data_d = shadow_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_SHOW: begin
                if (timer_done_s) begin
                    row_d   = row_inc_s;
                    timer_d = {TW{1'b0}};
                    if (en) begin
                        state_d       = ST_FETCH;
                        fetch_req_d   = 1'b1;
                        fetch_row_d   = row_inc_s;
                        frame_start_d = (row_inc_s == {RW{1'b0}});
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d    = timer_q + TW'(1);
                    row_sel_d  = row_onehot(row_q);
                    col_data_d = shadow_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
                row_d   = {RW{1'b0}};
                timer_d = {TW{1'b0}};
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            row_q         <= {RW{1'b0}};
            timer_q       <= {TW{1'b0}};
            limit_q       <= {TW{1'b0}};
            shadow_q      <= {COLS{1'b0}};
            fetch_req_q   <= 1'b0;
            fetch_row_q   <= {RW{1'b0}};
            row_sel_q     <= {ROWS{1'b0}};
            col_data_q    <= {COLS{1'b0}};
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            timer_q       <= timer_d;
            limit_q       <= limit_d;
            shadow_q      <= shadow_d;
            fetch_req_q   <= fetch_req_d;
            fetch_row_q   <= fetch_row_d;
            row_sel_q     <= row_sel_d;
            col_data_q    <= col_data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign fetch_req   = fetch_req_q;
    assign fetch_row   = fetch_row_q;
    assign row_sel     = row_sel_q;
    assign col_data    = col_data_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_panel_scan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_panel_scan_scheduler
//
// Directed bench for panel_scan_scheduler with ROWS=4. The bench plays the
// frame source: the pattern it returns on each ack is pushed to a queue and
// popped when the corresponding row appears on row_sel, so col_data is
// checked against what was actually handed over. Every row is walked cycle
// by cycle with the expected FETCH/BLANK/SHOW lengths, which pins row and
// frame periods as well as the per-cycle output values.
// ---------------------------------------------------------------------------
module tb_panel_scan_scheduler;

    localparam int ROWS    = 4;
    localparam int COLS    = 16;
    localparam int DWELL_W = 16;
    localparam int BLANK_W = 8;
    localparam int RW      = $clog2(ROWS);

    logic               clk;
    logic               reset;
    logic               en;
    logic [DWELL_W-1:0] dwell;
    logic [BLANK_W-1:0] blank;
    logic               fetch_req;
    logic [RW-1:0]      fetch_row;
    logic               fetch_ack;
    logic [COLS-1:0]    fetch_data;
    logic [ROWS-1:0]    row_sel;
    logic [COLS-1:0]    col_data;
    logic               frame_start;

    int n_cmp = 0;
    int n_bad = 0;
    logic [COLS-1:0] exp_q[$];

    panel_scan_scheduler #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .DWELL_W (DWELL_W),
        .BLANK_W (BLANK_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .dwell       (dwell),
        .blank       (blank),
        .fetch_req   (fetch_req),
        .fetch_row   (fetch_row),
        .fetch_ack   (fetch_ack),
        .fetch_data  (fetch_data),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req"}, 32'(fetch_req), 32'd0);
        check({tag, "_rowsel"}, 32'(row_sel), 32'd0);
        check({tag, "_col"}, 32'(col_data), 32'd0);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    // Walk one row starting at the negedge after FETCH was entered.
    // lat: ack delay after req rise; nblank/nshow: expected lengths;
    // spur: throw stray acks during BLANK/SHOW; mid_idx: SHOW cycle at which
    // en/dwell are changed; abort_idx: SHOW cycle at which reset is pulled low.
    task automatic row_cycle(input int exp_row, input bit exp_fs, input int lat,
                             input int nblank, input int nshow, input bit spur,
                             input int mid_idx, input bit en_mid,
                             input logic [DWELL_W-1:0] dwell_mid, input int abort_idx);
        logic [COLS-1:0] d;
        logic [COLS-1:0] expd;
        logic [ROWS-1:0] oh;
        oh = 4'b0001;
        oh = oh << exp_row;
        expd = 16'h0000;
        for (int i = 0; i <= lat; i++) begin
            check("fetch_req", 32'(fetch_req), 32'd1);
            check("fetch_row", 32'(fetch_row), 32'(exp_row));
            check("row_sel_fetch", 32'(row_sel), 32'd0);
            check("frame_start", 32'(frame_start), (i == 0) ? 32'(exp_fs) : 32'd0);
            if (i == lat) begin
                d = COLS'($urandom_range(0, 65535));
                fetch_data = d;
                fetch_ack  = 1'b1;
                exp_q.push_back(d);
            end else begin
                fetch_data = COLS'($urandom_range(0, 65535));
                fetch_ack  = 1'b0;
            end
            @(negedge clk);
        end
        fetch_ack = 1'b0;
        for (int b = 0; b < nblank; b++) begin
            check("blank_req", 32'(fetch_req), 32'd0);
            check("blank_rowsel", 32'(row_sel), 32'd0);
            check("blank_fs", 32'(frame_start), 32'd0);
            fetch_ack  = spur && (b % 2 == 0);
            fetch_data = 16'hDEAD;
            @(negedge clk);
        end
        for (int j = 0; j < nshow; j++) begin
            if (j == 0) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    expd = exp_q.pop_front();
                end
            end
            check("show_rowsel", 32'(row_sel), 32'(oh));
            check("show_col", 32'(col_data), 32'(expd));
            check("show_req", 32'(fetch_req), 32'd0);
            check("show_fs", 32'(frame_start), 32'd0);
            if (j == mid_idx) begin
                en    = en_mid;
                dwell = dwell_mid;
            end
            if (j == abort_idx) begin
                fetch_ack = 1'b0;
                #2 reset = 1'b0;
                #1;
                check("areset_rowsel", 32'(row_sel), 32'd0);
                check("areset_col", 32'(col_data), 32'd0);
                check("areset_req", 32'(fetch_req), 32'd0);
                check("areset_fs", 32'(frame_start), 32'd0);
                return;
            end
            fetch_ack  = spur && (j % 2 == 1);
            fetch_data = 16'hBEEF;
            @(negedge clk);
        end
        fetch_ack = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        en         = 1'b0;
        dwell      = 16'd5;
        blank      = 8'd2;
        fetch_ack  = 1'b0;
        fetch_data = 16'h0000;
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check_quiet("reset");
        check("reset_fetch_row", 32'(fetch_row), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_quiet("idle");

        // Zero-wait acks, dwell=5 blank=2: 8-cycle rows, 32-cycle frame
        en = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 5; r++) begin
            row_cycle(r % ROWS, (r % ROWS) == 0, 0, 2, 5, 1'b0, -1, 1'b1, 16'd5, -1);
        end

        // Ack 3 cycles after req: 4-cycle FETCH, 11-cycle rows
        row_cycle(1, 1'b0, 3, 2, 5, 1'b0, -1, 1'b1, 16'd5, -1);
        row_cycle(2, 1'b0, 3, 2, 5, 1'b0, -1, 1'b1, 16'd5, -1);

        // dwell=0 blank=0: each state one cycle, 3-cycle rows, 12-cycle frame
        dwell = 16'd0;
        blank = 8'd0;
        for (int r = 3; r < 8; r++) begin
            row_cycle(r % ROWS, (r % ROWS) == 0, 0, 1, 1, 1'b0, -1, 1'b1, 16'd0, -1);
        end

        // dwell 5 -> 9 mid-SHOW of row 1 with stray acks
        dwell = 16'd5;
        blank = 8'd2;
        row_cycle(0, 1'b1, 0, 2, 5, 1'b0, -1, 1'b1, 16'd5, -1);
        row_cycle(1, 1'b0, 0, 2, 5, 1'b1, 2, 1'b1, 16'd9, -1);
        row_cycle(2, 1'b0, 0, 2, 9, 1'b1, -1, 1'b1, 16'd9, -1);
        row_cycle(3, 1'b0, 1, 2, 9, 1'b0, -1, 1'b1, 16'd9, -1);

        // en dropped during SHOW of row 2: row completes, then IDLE
        row_cycle(0, 1'b1, 0, 2, 9, 1'b0, -1, 1'b1, 16'd9, -1);
        row_cycle(1, 1'b0, 0, 2, 9, 1'b0, -1, 1'b1, 16'd9, -1);
        row_cycle(2, 1'b0, 0, 2, 9, 1'b0, 3, 1'b0, 16'd9, -1);
        for (int k = 0; k < 4; k++) begin
            check_quiet("stopped");
            fetch_ack = (k == 1);
            @(negedge clk);
        end
        fetch_ack = 1'b0;
        en = 1'b1;
        @(negedge clk);
        row_cycle(0, 1'b1, 1, 2, 9, 1'b0, -1, 1'b1, 16'd9, -1);

        // Asynchronous reset mid-SHOW of row 1, then restart at row 0
        row_cycle(1, 1'b0, 0, 2, 9, 1'b0, -1, 1'b1, 16'd9, 2);
        @(negedge clk);
        check_quiet("held_reset");
        reset = 1'b1;
        @(negedge clk);
        row_cycle(0, 1'b1, 0, 2, 9, 1'b0, -1, 1'b1, 16'd9, -1);
        row_cycle(1, 1'b0, 0, 2, 9, 1'b0, -1, 1'b1, 16'd9, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
